// File: rtl/div_unit_pkg.sv
// Shared types and constants for the divide unit front end.
// Holds the RISC-V M divide op encoding, the control FSM states and special operand values.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        BUSY  = 2'b10,
        DONE  = 2'b11
    } div_state_e;

    localparam logic [31:0] INT_MIN  = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_special_chk.sv
// Detects divide-by-zero and signed overflow, and produces the architectural result for them.
// These cases never reach the divider core.
module div_special_chk
    import div_unit_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        is_special,
    output logic [31:0] result
);

    logic div_by_zero;
    logic overflow;

    // op[0] clear means signed; op[1] set means the remainder is wanted
    always_comb begin
        div_by_zero = (b == 32'd0);
        overflow    = ~op[0] && (a == INT_MIN) && (b == ALL_ONES);
        is_special  = div_by_zero || overflow;
        result      = 32'd0;
        if (div_by_zero) begin
            result = op[1] ? a : ALL_ONES;
        end else if (overflow) begin
            result = op[1] ? 32'd0 : INT_MIN;
        end
    end

endmodule

// File: rtl/div_unit.sv
// Divide unit front end: accepts EX-stage requests, resolves special cases locally,
// sequences the external divider core and holds the result until writeback accepts it.
module div_unit
    import div_unit_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [4:0]  req_rd,
    output logic        div_in_valid,
    input  logic        div_in_ready,
    output logic        div_sign,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic        div_out_valid,
    output logic        div_out_ready,
    input  logic [31:0] div_quot,
    input  logic [31:0] div_rem,
    output logic        div_flush,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd
);

    div_state_e  state_q, state_d;
    div_op_e     op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] result_q, result_d;

    logic        is_special;
    logic [31:0] special_result;

    div_special_chk u_special_chk (
        .op         (req_op),
        .a          (req_a),
        .b          (req_b),
        .is_special (is_special),
        .result     (special_result)
    );

    // Core-facing operands come straight from the latched request so they stay stable while issuing
    assign req_ready     = (state_q == IDLE) && !flush;
    assign div_in_valid  = (state_q == ISSUE);
    assign div_out_ready = (state_q == BUSY);
    assign div_sign      = ~op_q[0];
    assign div_a         = a_q;
    assign div_b         = b_q;
    assign div_flush     = flush;
    assign wb_valid      = (state_q == DONE);
    assign wb_data       = result_q;
    assign wb_rd         = rd_q;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        rd_d     = rd_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    op_d = div_op_e'(req_op);
                    a_d  = req_a;
                    b_d  = req_b;
                    rd_d = req_rd;
                    if (is_special) begin
                        result_d = special_result;
                        state_d  = DONE;
                    end else begin
                        state_d  = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (div_in_ready) state_d = BUSY;
            end
            BUSY: begin
                if (div_out_valid) begin
                    result_d = op_q[1] ? div_rem : div_quot;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (wb_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A flush wins over any handshake in the same cycle, including a writeback handoff
        if (flush) begin
            state_d  = IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= DIV;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            rd_q     <= 5'd0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rd_q     <= rd_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit with a small behavioural divider core attached.
module tb_div_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] req_a = 32'd0;
    logic [31:0] req_b = 32'd0;
    logic [4:0]  req_rd = 5'd0;
    logic        div_in_valid;
    logic        div_in_ready = 1'b1;
    logic        div_sign;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_out_valid;
    logic        div_out_ready;
    logic [31:0] div_quot;
    logic [31:0] div_rem;
    logic        div_flush;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;

    int checks = 0;
    int failures = 0;
    int issue_count = 0;

    // Behavioural divider core with a programmable latency
    logic        core_busy = 1'b0;
    logic        core_out_valid = 1'b0;
    logic        inject_out_valid = 1'b0;
    int          core_cnt = 0;
    int          core_lat = 3;
    logic [31:0] core_quot = 32'd0;
    logic [31:0] core_rem = 32'd0;

    assign div_out_valid = core_out_valid || inject_out_valid;
    assign div_quot      = core_quot;
    assign div_rem       = core_rem;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (div_in_valid) issue_count <= issue_count + 1;
        if (reset || div_flush) begin
            core_busy      <= 1'b0;
            core_out_valid <= 1'b0;
        end else if (core_out_valid) begin
            if (div_out_ready) core_out_valid <= 1'b0;
        end else if (!core_busy && div_in_valid && div_in_ready) begin
            core_busy <= 1'b1;
            core_cnt  <= core_lat;
            if (div_sign) begin
                core_quot <= $signed(div_a) / $signed(div_b);
                core_rem  <= $signed(div_a) % $signed(div_b);
            end else begin
                core_quot <= div_a / div_b;
                core_rem  <= div_a % div_b;
            end
        end else if (core_busy) begin
            if (core_cnt <= 1) begin
                core_busy      <= 1'b0;
                core_out_valid <= 1'b1;
            end else begin
                core_cnt <= core_cnt - 1;
            end
        end
    end

    div_unit dut (
        .clock         (clock),
        .reset         (reset),
        .flush         (flush),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_rd        (req_rd),
        .div_in_valid  (div_in_valid),
        .div_in_ready  (div_in_ready),
        .div_sign      (div_sign),
        .div_a         (div_a),
        .div_b         (div_b),
        .div_out_valid (div_out_valid),
        .div_out_ready (div_out_ready),
        .div_quot      (div_quot),
        .div_rem       (div_rem),
        .div_flush     (div_flush),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_data       (wb_data),
        .wb_rd         (wb_rd)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Presents one request for a single cycle; the DUT is expected to be idle
    task automatic send_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_rd    = rd;
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_wb(output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (wb_valid) begin
                timed_out = 1'b0;
                break;
            end
            step();
        end
    endtask

    task automatic handoff();
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_req_ready got=%b exp=1", req_ready); end
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_wb_valid got=%b exp=0", wb_valid); end
        checks++; if (div_in_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_div_in_valid got=%b exp=0", div_in_valid); end
        checks++; if (div_out_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_div_out_ready got=%b exp=0", div_out_ready); end
        checks++; if (wb_data !== 32'd0) begin failures++; $display("[TB] FAIL reset_wb_data got=%h exp=0", wb_data); end
        checks++; if (wb_rd !== 5'd0) begin failures++; $display("[TB] FAIL reset_wb_rd got=%0d exp=0", wb_rd); end
    endtask

    task automatic test_signed_div();
        bit to;
        send_req(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd7);
        checks++; if (div_in_valid !== 1'b1) begin failures++; $display("[TB] FAIL sdiv_issue got=%b exp=1", div_in_valid); end
        checks++; if (div_sign !== 1'b1) begin failures++; $display("[TB] FAIL sdiv_sign got=%b exp=1", div_sign); end
        checks++; if (div_a !== 32'hFFFF_FFF9 || div_b !== 32'd2) begin failures++; $display("[TB] FAIL sdiv_operands got=%h/%h exp=fffffff9/00000002", div_a, div_b); end
        wait_wb(to);
        checks++; if (to) begin failures++; $display("[TB] FAIL sdiv_timeout got=no wb_valid exp=wb_valid"); end
        checks++; if (wb_data !== 32'hFFFF_FFFD) begin failures++; $display("[TB] FAIL sdiv_data got=%h exp=fffffffd", wb_data); end
        checks++; if (wb_rd !== 5'd7) begin failures++; $display("[TB] FAIL sdiv_rd got=%0d exp=7", wb_rd); end
        handoff();
        checks++; if (req_ready !== 1'b1 || wb_valid !== 1'b0) begin failures++; $display("[TB] FAIL sdiv_return_idle got=%b/%b exp=1/0", req_ready, wb_valid); end
    endtask

    task automatic test_div_by_zero();
        int issues_before;
        issues_before = issue_count;
        send_req(2'b11, 32'd5, 32'd0, 5'd3);
        checks++; if (wb_valid !== 1'b1) begin failures++; $display("[TB] FAIL remu0_wb_valid got=%b exp=1", wb_valid); end
        checks++; if (wb_data !== 32'h0000_0005) begin failures++; $display("[TB] FAIL remu0_data got=%h exp=00000005", wb_data); end
        checks++; if (wb_rd !== 5'd3) begin failures++; $display("[TB] FAIL remu0_rd got=%0d exp=3", wb_rd); end
        handoff();
        send_req(2'b01, 32'd5, 32'd0, 5'd4);
        checks++; if (wb_valid !== 1'b1) begin failures++; $display("[TB] FAIL divu0_wb_valid got=%b exp=1", wb_valid); end
        checks++; if (wb_data !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL divu0_data got=%h exp=ffffffff", wb_data); end
        handoff();
        checks++; if (issue_count !== issues_before) begin failures++; $display("[TB] FAIL div0_no_issue got=%0d exp=%0d", issue_count, issues_before); end
    endtask

    task automatic test_overflow();
        int issues_before;
        issues_before = issue_count;
        send_req(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
        checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h8000_0000) begin failures++; $display("[TB] FAIL ovf_div got=%b/%h exp=1/80000000", wb_valid, wb_data); end
        handoff();
        send_req(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
        checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h0000_0000) begin failures++; $display("[TB] FAIL ovf_rem got=%b/%h exp=1/00000000", wb_valid, wb_data); end
        handoff();
        checks++; if (issue_count !== issues_before) begin failures++; $display("[TB] FAIL ovf_no_issue got=%0d exp=%0d", issue_count, issues_before); end
    endtask

    task automatic test_flush_busy();
        bit to;
        bit seen_wb;
        core_lat = 20;
        send_req(2'b01, 32'd5000, 32'd3, 5'd9);
        to = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (div_out_ready) begin
                to = 1'b0;
                break;
            end
            step();
        end
        checks++; if (to) begin failures++; $display("[TB] FAIL flush_busy_timeout got=no busy exp=busy"); end
        for (int i = 0; i < 9; i++) step();
        flush = 1'b1;
        #1;
        checks++; if (div_flush !== 1'b1) begin failures++; $display("[TB] FAIL flush_forward got=%b exp=1", div_flush); end
        step();
        flush = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1 || div_out_ready !== 1'b0) begin failures++; $display("[TB] FAIL flush_idle got=%b/%b exp=1/0", req_ready, div_out_ready); end
        seen_wb = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (wb_valid) seen_wb = 1'b1;
            step();
        end
        checks++; if (seen_wb !== 1'b0) begin failures++; $display("[TB] FAIL flush_no_wb got=%b exp=0", seen_wb); end
        core_lat = 3;
        send_req(2'b01, 32'd100, 32'd7, 5'd12);
        wait_wb(to);
        checks++; if (to || wb_data !== 32'd14) begin failures++; $display("[TB] FAIL flush_next_divu got=%h exp=0000000e", wb_data); end
        handoff();
    endtask

    task automatic test_wb_stall();
        bit to;
        send_req(2'b01, 32'd100, 32'd7, 5'd21);
        wait_wb(to);
        checks++; if (to) begin failures++; $display("[TB] FAIL stall_timeout got=no wb_valid exp=wb_valid"); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (wb_valid !== 1'b1 || wb_data !== 32'd14 || wb_rd !== 5'd21 || req_ready !== 1'b0) begin
                failures++; $display("[TB] FAIL stall_hold got=%b/%h/%0d/%b exp=1/0000000e/21/0", wb_valid, wb_data, wb_rd, req_ready);
            end
            step();
        end
        handoff();
        checks++; if (req_ready !== 1'b1 || wb_valid !== 1'b0) begin failures++; $display("[TB] FAIL stall_release got=%b/%b exp=1/0", req_ready, wb_valid); end
    endtask

    task automatic test_issue_stall();
        bit to;
        div_in_ready = 1'b0;
        send_req(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd30);
        for (int i = 0; i < 2; i++) begin
            checks++; if (div_in_valid !== 1'b1 || div_a !== 32'hFFFF_FFF9 || div_b !== 32'd2 || div_sign !== 1'b1 || div_out_ready !== 1'b0) begin
                failures++; $display("[TB] FAIL issue_hold got=%b/%h/%h/%b/%b exp=1/fffffff9/00000002/1/0", div_in_valid, div_a, div_b, div_sign, div_out_ready);
            end
            step();
        end
        div_in_ready = 1'b1;
        step();
        checks++; if (div_out_ready !== 1'b1 || div_in_valid !== 1'b0) begin failures++; $display("[TB] FAIL issue_to_busy got=%b/%b exp=1/0", div_out_ready, div_in_valid); end
        wait_wb(to);
        checks++; if (to || wb_data !== 32'hFFFF_FFFF || wb_rd !== 5'd30) begin failures++; $display("[TB] FAIL issue_rem got=%h/%0d exp=ffffffff/30", wb_data, wb_rd); end
        handoff();
    endtask

    task automatic test_flush_and_stray();
        int issues_before;
        issues_before = issue_count;
        req_valid = 1'b1;
        req_op    = 2'b01;
        req_a     = 32'd9;
        req_b     = 32'd3;
        flush     = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b0) begin failures++; $display("[TB] FAIL flush_req_ready got=%b exp=0", req_ready); end
        step();
        req_valid = 1'b0;
        flush     = 1'b0;
        #1;
        checks++; if (div_in_valid !== 1'b0 || wb_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("[TB] FAIL flush_req_dropped got=%b/%b/%b exp=0/0/1", div_in_valid, wb_valid, req_ready); end
        inject_out_valid = 1'b1;
        step();
        inject_out_valid = 1'b0;
        checks++; if (wb_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("[TB] FAIL stray_out_valid got=%b/%b exp=0/1", wb_valid, req_ready); end
        checks++; if (issue_count !== issues_before) begin failures++; $display("[TB] FAIL flush_req_no_issue got=%0d exp=%0d", issue_count, issues_before); end
    endtask

    initial begin
        test_reset();
        test_signed_div();
        test_div_by_zero();
        test_overflow();
        test_flush_busy();
        test_wb_stall();
        test_issue_stall();
        test_flush_and_stray();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
